// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: FSM state encoding and
// EX operand forwarding select codes.
package core_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    STALL = ST_STALL,
    FLUSH = ST_FLUSH
  } state_t;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select: EX/MEM result beats MEM/WB data, and
// x0 is never forwarded because it is hardwired to zero.
module fwd_unit
  import core_pkg::*;
(
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             memwb_reg_write,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic [REG_W-1:0] idex_rs1,
  input  logic [REG_W-1:0] idex_rs2,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  function automatic logic [1:0] fwd_sel(
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd,
    input logic [REG_W-1:0] rs
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, idex_rs1);
    fwd_b = fwd_sel(exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, idex_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// forwarding selects and saturating debug event counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IFID_rs1,
  input  logic [REG_W-1:0] IFID_rs2,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_rd,
  input  logic [REG_W-1:0] IDEX_rs1,
  input  logic [REG_W-1:0] IDEX_rs2,
  input  logic             EXMEM_RegWrite,
  input  logic [REG_W-1:0] EXMEM_rd,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             MEMWB_RegWrite,
  input  logic [REG_W-1:0] MEMWB_rd,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Bubbles still owed after the one issued in the detecting RUN cycle.
  localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] stall_cnt, stall_cnt_next;
  logic       taken, loaduse;
  logic       pc_write, ifid_write, bubble, flush, flush_evt;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign taken   = EXMEM_Branch & EXMEM_Zero;
  assign loaduse = IDEX_MemRead && (IDEX_rd != '0) &&
                   ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

  fwd_unit u_fwd (
    .exmem_reg_write (EXMEM_RegWrite),
    .exmem_rd        (EXMEM_rd),
    .memwb_reg_write (MEMWB_RegWrite),
    .memwb_rd        (MEMWB_rd),
    .idex_rs1        (IDEX_rs1),
    .idex_rs2        (IDEX_rs2),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    bubble         = 1'b0;
    flush          = 1'b0;
    flush_evt      = 1'b0;
    case (state)
      RUN: begin
        if (taken) begin
          flush      = 1'b1;
          flush_evt  = 1'b1;
          state_next = FLUSH;
        end else if (loaduse) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          bubble         = 1'b1;
          stall_cnt_next = STALL_LOAD;
          if (STALL_LOAD != 3'd0) state_next = STALL;
        end
      end
      STALL: begin
        if (taken) begin
          flush      = 1'b1;
          flush_evt  = 1'b1;
          state_next = FLUSH;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          // stall_cnt counts this bubble too, so the last one exits at 1.
          if (stall_cnt <= 3'd1) state_next = RUN;
          else stall_cnt_next = stall_cnt - 3'd1;
        end
      end
      FLUSH: begin
        flush      = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Reset overrides the combinational controls so no bubble or flush leaks out.
  assign PCWrite     = reset | pc_write;
  assign IFID_Write  = reset | ifid_write;
  assign IDEX_Bubble = ~reset & bubble;
  assign Flush       = ~reset & flush;
  assign ForwardA    = reset ? FWD_RF : fwd_a;
  assign ForwardB    = reset ? FWD_RF : fwd_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      stall_cnt   <= 3'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      if (bubble)    stall_count <= sat_inc(stall_count);
      if (flush_evt) flush_count <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (1-cycle stall, 3-cycle
// stall, 4-bit counters) share stimulus; table vectors plus corner sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, ex_rd, ex_rs1, ex_rs2, em_rd, mw_rd;
  logic       mr, em_rw, br, zr, mw_rw;

  logic [2:0]  pcw, ifw, bub, fl;
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [3:0]  sc4, fc4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .IFID_rs1(rs1), .IFID_rs2(rs2),
    .IDEX_MemRead(mr), .IDEX_rd(ex_rd), .IDEX_rs1(ex_rs1), .IDEX_rs2(ex_rs2),
    .EXMEM_RegWrite(em_rw), .EXMEM_rd(em_rd), .EXMEM_Branch(br), .EXMEM_Zero(zr),
    .MEMWB_RegWrite(mw_rw), .MEMWB_rd(mw_rd),
    .PCWrite(pcw[0]), .IFID_Write(ifw[0]), .IDEX_Bubble(bub[0]), .Flush(fl[0]),
    .ForwardA(fa[0]), .ForwardB(fb[0]), .stall_count(sc1), .flush_count(fc1));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .IFID_rs1(rs1), .IFID_rs2(rs2),
    .IDEX_MemRead(mr), .IDEX_rd(ex_rd), .IDEX_rs1(ex_rs1), .IDEX_rs2(ex_rs2),
    .EXMEM_RegWrite(em_rw), .EXMEM_rd(em_rd), .EXMEM_Branch(br), .EXMEM_Zero(zr),
    .MEMWB_RegWrite(mw_rw), .MEMWB_rd(mw_rd),
    .PCWrite(pcw[1]), .IFID_Write(ifw[1]), .IDEX_Bubble(bub[1]), .Flush(fl[1]),
    .ForwardA(fa[1]), .ForwardB(fb[1]), .stall_count(sc3), .flush_count(fc3));

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .IFID_rs1(rs1), .IFID_rs2(rs2),
    .IDEX_MemRead(mr), .IDEX_rd(ex_rd), .IDEX_rs1(ex_rs1), .IDEX_rs2(ex_rs2),
    .EXMEM_RegWrite(em_rw), .EXMEM_rd(em_rd), .EXMEM_Branch(br), .EXMEM_Zero(zr),
    .MEMWB_RegWrite(mw_rw), .MEMWB_rd(mw_rd),
    .PCWrite(pcw[2]), .IFID_Write(ifw[2]), .IDEX_Bubble(bub[2]), .Flush(fl[2]),
    .ForwardA(fa[2]), .ForwardB(fb[2]), .stall_count(sc4), .flush_count(fc4));

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       mr;
    logic [4:0] ex_rd, ex_rs1, ex_rs2;
    logic       em_rw;
    logic [4:0] em_rd;
    logic       br, zr, mw_rw;
    logic [4:0] mw_rd;
    logic [7:0] want;  // {PCWrite, IFID_Write, IDEX_Bubble, Flush, ForwardA, ForwardB}
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; mr = 0; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    em_rw = 0; em_rd = 0; br = 0; zr = 0; mw_rw = 0; mw_rd = 0;
  endtask

  task automatic ld_use();
    mr = 1; ex_rd = 5; rs1 = 5; rs2 = 0;
  endtask

  task automatic take();
    br = 1; zr = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1; #1; reset = 0; #1;
  endtask

  initial begin
    //         rs1 rs2 mr exrd exs1 exs2 emw emrd br zr mww mwrd  want
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000};
    vecs[1]  = '{5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0010_0000};
    vecs[2]  = '{3, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0010_0000};
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000};
    vecs[4]  = '{5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000};
    vecs[5]  = '{6, 7, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1100_0000};
    vecs[6]  = '{5, 0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 8'b1101_0000};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'b1100_0000};
    vecs[8]  = '{0, 0, 0, 0, 7, 0, 1, 7, 0, 0, 1, 7, 8'b1100_1000};
    vecs[9]  = '{0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 1, 7, 8'b1100_0100};
    vecs[10] = '{0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 1, 0, 8'b1100_0000};
    vecs[11] = '{0, 0, 0, 0, 3, 9, 1, 9, 0, 0, 0, 0, 8'b1100_0010};
    vecs[12] = '{0, 0, 0, 0, 9, 9, 0, 9, 0, 0, 1, 9, 8'b1100_0101};
    vecs[13] = '{0, 0, 0, 0, 9, 9, 0, 9, 0, 0, 0, 9, 8'b1100_0000};
    vecs[14] = '{0, 0, 0, 0, 4, 9, 1, 4, 0, 0, 1, 9, 8'b1100_1001};

    idle();
    reset = 1;
    @(negedge clk);
    #1;
    chk("reset_outputs", {pcw[0], ifw[0], bub[0], fl[0], fa[0], fb[0]}, 8'b1100_0000);
    chk("reset_counts", sc1 | fc1 | sc3 | fc3, 32'd0);
    reset = 0;
    cyc();
    #1;
    chk("post_reset_pcwrite", {pcw[0], bub[0]}, 2'b10);

    // Combinational control from RUN; idle again before each edge keeps RUN.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; mr = vecs[i].mr;
      ex_rd = vecs[i].ex_rd; ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
      em_rw = vecs[i].em_rw; em_rd = vecs[i].em_rd; br = vecs[i].br; zr = vecs[i].zr;
      mw_rw = vecs[i].mw_rw; mw_rd = vecs[i].mw_rd;
      #1;
      chk($sformatf("vec%0d", i), {pcw[0], ifw[0], bub[0], fl[0], fa[0], fb[0]}, vecs[i].want);
      idle();
    end

    // Load-use: one bubble with STALL_CYCLES=1, three with STALL_CYCLES=3.
    @(negedge clk);
    pulse_reset();
    ld_use();
    #1;
    chk("lu_c1_dut1", {pcw[0], ifw[0], bub[0]}, 3'b001);
    chk("lu_c1_dut3", {pcw[1], ifw[1], bub[1]}, 3'b001);
    cyc();
    idle();
    #1;
    chk("lu_c2_dut1", {pcw[0], ifw[0], bub[0]}, 3'b110);
    chk("lu_c2_dut3", {pcw[1], ifw[1], bub[1]}, 3'b001);
    cyc();
    #1;
    chk("lu_c3_dut3", {pcw[1], ifw[1], bub[1]}, 3'b001);
    cyc();
    #1;
    chk("lu_c4_dut3", {pcw[1], ifw[1], bub[1]}, 3'b110);
    chk("lu_stall_count_dut1", sc1, 32'd1);
    chk("lu_stall_count_dut3", sc3, 32'd3);

    // Taken branch beats a simultaneous load-use: two flush cycles, no bubble.
    pulse_reset();
    take();
    ld_use();
    #1;
    chk("br_c1", {pcw[0], bub[0], fl[0]}, 3'b101);
    cyc();
    idle();
    #1;
    chk("br_c2", {pcw[0], ifw[0], bub[0], fl[0]}, 4'b1101);
    cyc();
    #1;
    chk("br_c3", {bub[0], fl[0]}, 2'b00);
    chk("br_flush_count", fc1, 32'd1);
    chk("br_stall_count", sc1, 32'd0);

    // Taken branch in the second of three stall cycles abandons the stall.
    pulse_reset();
    ld_use();
    cyc();
    idle();
    take();
    #1;
    chk("abandon_c2", {pcw[1], ifw[1], bub[1], fl[1]}, 4'b1101);
    cyc();
    idle();
    #1;
    chk("abandon_c3", {pcw[1], bub[1], fl[1]}, 3'b101);
    cyc();
    #1;
    chk("abandon_c4", {pcw[1], bub[1], fl[1]}, 3'b100);
    chk("abandon_counts", {fc3[7:0], sc3[7:0]}, 16'h0101);

    // Reset mid-stall with hazard and forwarding inputs active.
    pulse_reset();
    ld_use();
    cyc();
    idle();
    #1;
    chk("mid_stall_bubble", bub[1], 1'b1);
    ld_use();
    em_rw = 1; em_rd = 7; ex_rs1 = 7; ex_rs2 = 7;
    reset = 1;
    #1;
    chk("rst_stall_dut1", {pcw[0], ifw[0], bub[0], fl[0], fa[0], fb[0]}, 8'b1100_0000);
    chk("rst_stall_dut3", {pcw[1], ifw[1], bub[1], fl[1]}, 4'b1100);
    chk("rst_stall_count", sc3, 32'd0);
    cyc();
    idle();
    reset = 0;
    cyc();
    #1;
    chk("rst_release", {pcw[1], bub[1], fl[1]}, 3'b100);

    // Reset in the flush cycle.
    take();
    cyc();
    idle();
    #1;
    chk("mid_flush", fl[0], 1'b1);
    reset = 1;
    #1;
    chk("rst_flush", {fl[0], fc1[7:0]}, 9'd0);
    reset = 0;
    cyc();
    #1;
    chk("rst_flush_after", {pcw[0], fl[0]}, 2'b10);

    // Saturation with 4-bit counters.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      ld_use();
      cyc();
      idle();
      cyc();
    end
    chk("sat_stall_dut4", sc4, 4'd15);
    chk("stall_dut1_20", sc1, 32'd20);
    for (int i = 0; i < 20; i++) begin
      take();
      cyc();
      idle();
      cyc();
    end
    chk("sat_flush_dut4", fc4, 4'd15);
    chk("flush_dut1_20", fc1, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
